cdc_wr_ctrl: RTL
================

CDC_WR_CTRL -- requirements
Module: cdc_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3: pointer width; FIFO holds 2**ADDR_WIDTH-1 usable entries.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: flop stages on the incoming read pointer.
REQ-003 clk  in  1  single write-domain clock; all flops rise-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 terminate  in  1  synchronous flush of write-side state.
REQ-006 infoInValid  in  1  upstream has a word to write.
REQ-007 rdPtr_gray  in  ADDR_WIDTH  read-domain Gray pointer, asynchronous to clk.
REQ-008 infoInReady  out  1  FIFO can accept a word this cycle.
REQ-009 fifoWe  out  1  RAM write enable.
REQ-010 wrAddr  out  ADDR_WIDTH  binary RAM write address.
REQ-011 wrPtr_gray  out  ADDR_WIDTH  registered Gray write pointer, sent to the read domain.
REQ-012 nextwrPtr_gray  out  ADDR_WIDTH  Gray of wrAddr+1, combinational.

Function
REQ-013 fifoWe = infoInValid AND infoInReady AND NOT terminate, combinational.
REQ-014 infoInReady = NOT full, where full is a registered flag.
REQ-015 On fifoWe, wrAddr increments modulo 2**ADDR_WIDTH.
- Wrap 2**ADDR_WIDTH-1 -> 0 needs no special case.
REQ-016 On fifoWe, wrPtr_gray is loaded in the same edge with bin2gray(wrAddr+1).
- wrPtr_gray always equals bin2gray(wrAddr).
- wrPtr_gray comes directly from flops, never from combinational logic.
REQ-017 bin2gray(b) = b XOR (b >> 1).
REQ-018 rdPtr_gray passes through SYNC_STAGES flops to form rdSync.
- Per-bit resynchronisation.
- No combinational logic before the first stage.
REQ-019 full update, each non-terminate edge:
- If fifoWe: full <= (bin2gray(wrAddr+2) == rdSync).
- Else: full <= (bin2gray(wrAddr+1) == rdSync).
REQ-020 full is conservative.
- A stale rdSync can only hold full high longer, never drop it early.
- Overflow is impossible for any read-side timing.
REQ-021 Latency:
- A write is visible on wrPtr_gray 1 cycle after fifoWe.
- A read-side pointer advance can deassert full no earlier than SYNC_STAGES+1 clk edges after rdPtr_gray changes.
REQ-022 terminate has priority over fifoWe. On an edge with terminate=1:
- wrAddr, wrPtr_gray and all sync stages are set to 0.
- full is set to 1.
REQ-023 After terminate falls, full re-evaluates per REQ-019 on the next edge.
- Ready returns 1 cycle later if the read side is also flushed.
REQ-024 infoInValid may rise or fall in any cycle; no write occurs while infoInReady=0.

Reset
REQ-025 On rst low, asynchronously:
- wrAddr=0, wrPtr_gray=0, all sync stages=0, full=1.
- Therefore infoInReady=0 and fifoWe=0.
REQ-026 full deasserts on the first edge after rst release.
- bin2gray(1) differs from rdSync=0.
REQ-027 Reset asserted mid-operation discards all write-side state immediately; no partial write completes.

Structure
REQ-028 Shared package cdc_pkg holds:
- the bin2gray function;
- the default ADDR_WIDTH and SYNC_STAGES constants.
- The read-side controller uses this package too.
REQ-029 One sub-module, cdc_gray_sync:
- Parameterised width and stage count.
- Async active-low reset to 0 and synchronous clear input (driven by terminate).
- Reusable for the wr->rd direction.
REQ-030 The top-level cdc_wr_ctrl holds the pointer counter, the Gray register and the full flag only.

Verification (ADDR_WIDTH=3, SYNC_STAGES=2)
REQ-031 Reset release, infoInValid=1, rdPtr_gray held 000:
- infoInReady=0 at the first edge, then 1.
- Exactly 7 writes occur.
- wrPtr_gray steps 001,011,010,110,111,101,100.
- infoInReady falls the cycle after the 7th write.
REQ-032 From the full state, step rdPtr_gray to 001:
- infoInReady rises exactly 3 edges later.
- One write occurs; wrAddr wraps 7 -> 0.
- wrPtr_gray=000.
- Full again.
REQ-033 Continuous write and read stream, 1000 cycles:
- No write occurs while full.
- wrPtr_gray changes by exactly one bit per write.
- wrAddr == gray2bin(wrPtr_gray) every cycle.
REQ-034 terminate pulse during a write after 4 entries (infoInValid=1):
- fifoWe=0 in that cycle.
- Next cycle: wrAddr=0, wrPtr_gray=000, infoInReady=0.
- infoInReady=1 one cycle later.
REQ-035 rst asserted mid-burst, between edges:
- Outputs go to reset values with no clk edge.
- fifoWe=0 immediately.
REQ-036 infoInValid toggled randomly with rdPtr_gray static:
- Write count equals the number of valid-and-ready cycles, capped at 7.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC FIFO pointer controllers (write and read sides).
// Holds the default geometry and the binary-to-Gray helper.
package cdc_pkg;

  localparam int CDC_ADDR_WIDTH  = 3;
  localparam int CDC_SYNC_STAGES = 2;
  // Widest pointer the helper supports; callers zero-extend and cast back down.
  localparam int CDC_MAX_W       = 16;

  function automatic logic [CDC_MAX_W-1:0] bin2gray(input logic [CDC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/cdc_gray_sync.sv
// Multi-flop resynchroniser for a Gray-coded pointer crossing into the clk domain.
// Each bit is captured independently; no logic sits in front of the first stage.
module cdc_gray_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stageReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stageReg <= '0;
    end else if (clr) begin
      stageReg <= '0;
    end else begin
      stageReg <= {stageReg[STAGES-2:0], din};
    end
  end

  assign dout = stageReg[STAGES-1];

endmodule

// File: rtl/cdc_wr_ctrl.sv
// Write-side pointer controller of an asynchronous FIFO: binary RAM address,
// registered Gray write pointer and a conservative registered full flag.
module cdc_wr_ctrl
  import cdc_pkg::*;
#(
  parameter int ADDR_WIDTH  = CDC_ADDR_WIDTH,
  parameter int SYNC_STAGES = CDC_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  terminate,
  input  logic                  infoInValid,
  input  logic [ADDR_WIDTH-1:0] rdPtr_gray,
  output logic                  infoInReady,
  output logic                  fifoWe,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  output logic [ADDR_WIDTH-1:0] wrPtr_gray,
  output logic [ADDR_WIDTH-1:0] nextwrPtr_gray
);

  logic [ADDR_WIDTH-1:0] wrAddrReg;
  logic [ADDR_WIDTH-1:0] wrGrayReg;
  logic                  fullReg;
  logic [ADDR_WIDTH-1:0] rdSync;
  logic [ADDR_WIDTH-1:0] addrPlus1;
  logic [ADDR_WIDTH-1:0] addrPlus2;
  logic [ADDR_WIDTH-1:0] grayPlus1;
  logic [ADDR_WIDTH-1:0] grayPlus2;

  cdc_gray_sync #(
    .WIDTH  (ADDR_WIDTH),
    .STAGES (SYNC_STAGES)
  ) uRdSync (
    .clk  (clk),
    .rst  (rst),
    .clr  (terminate),
    .din  (rdPtr_gray),
    .dout (rdSync)
  );

  // Modulo-2**ADDR_WIDTH arithmetic makes the wrap free.
  assign addrPlus1 = wrAddrReg + ADDR_WIDTH'(1);
  assign addrPlus2 = wrAddrReg + ADDR_WIDTH'(2);
  assign grayPlus1 = ADDR_WIDTH'(bin2gray(CDC_MAX_W'(addrPlus1)));
  assign grayPlus2 = ADDR_WIDTH'(bin2gray(CDC_MAX_W'(addrPlus2)));

  assign infoInReady    = ~fullReg;
  assign fifoWe         = infoInValid & ~fullReg & ~terminate;
  assign wrAddr         = wrAddrReg;
  assign wrPtr_gray     = wrGrayReg;
  assign nextwrPtr_gray = grayPlus1;

  // Full compares the pointer after the pending write against a possibly stale
  // read pointer; staleness can only keep full asserted longer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrAddrReg <= '0;
      wrGrayReg <= '0;
      fullReg   <= 1'b1;
    end else if (terminate) begin
      wrAddrReg <= '0;
      wrGrayReg <= '0;
      fullReg   <= 1'b1;
    end else if (fifoWe) begin
      wrAddrReg <= addrPlus1;
      wrGrayReg <= grayPlus1;
      fullReg   <= (grayPlus2 == rdSync);
    end else begin
      fullReg   <= (grayPlus1 == rdSync);
    end
  end

endmodule
